// File: rtl/cmp_share_pkg.sv
// Shared types and constants for the comparator-sharing arbiter.
package cmp_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic g;
        logic l;
        logic e;
    } cmp_res_t;

    localparam int EQ_CNT_W   = 8;
    localparam int EQ_CNT_MAX = 255;

endpackage

// File: rtl/mag_cmp_core.sv
// Unsigned magnitude comparator; the single shared datapath resource.
module mag_cmp_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             g,
    output logic             l,
    output logic             e
);

    assign g = (a > b);
    assign l = (a < b);
    assign e = (a == b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ clients.
// IDLE grants one requester and latches its operands, CMP registers the
// compare result, RESP holds it until the consumer takes it.
// Optional build macro CMP_SHARE_STATS_EN adds a saturating count of
// equal results (eq_count) with a clear input (stats_clr).
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_g,
    output logic                  rsp_l,
    output logic                  rsp_e,
`ifdef CMP_SHARE_STATS_EN
    input  logic                  stats_clr,
    output logic [EQ_CNT_W-1:0]   eq_count,
`endif
    output logic                  busy
);

    // Add modulo NREQ; both operands are always below NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] x,
                                                input logic [IDW-1:0] y);
        logic [IDW:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= (IDW+1)'(NREQ))
            sum = sum - (IDW+1)'(NREQ);
        return sum[IDW-1:0];
    endfunction

    state_t                      state, state_nxt;
    logic [IDW-1:0]              rr_ptr;
    logic [IDW-1:0]              grant;
    logic [IDW-1:0]              grant_q;
    logic [IDW-1:0]              pick;
    logic [NREQ-1:0]             rot;
    logic                        accept;
    logic                        done;
    logic [WIDTH-1:0]            a_q, b_q;
    logic [NREQ-1:0][WIDTH-1:0]  a_arr, b_arr;
    cmp_res_t                    res_c, res_q;

    assign a_arr = req_a;
    assign b_arr = req_b;

    // Rotate the valid vector so rr_ptr becomes position 0.
    always_comb begin
        rot = '0;
        for (int k = 0; k < NREQ; k++)
            rot[k] = req_valid[wrap_add(rr_ptr, IDW'(k))];
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        pick = '0;
        for (int k = NREQ-1; k >= 0; k--)
            if (rot[k]) pick = IDW'(k);
    end

    // Un-rotate the winner back to a requester index.
    assign grant = wrap_add(rr_ptr, pick);

    // The one shared comparator sees only the latched operands.
    mag_cmp_core #(.WIDTH(WIDTH)) u_cmp (
        .a (a_q),
        .b (b_q),
        .g (res_c.g),
        .l (res_c.l),
        .e (res_c.e)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and the combinational accept pulse; reset masks any grant.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: if (|req_valid) begin
                accept           = 1'b1;
                req_ready[grant] = 1'b1;
                state_nxt        = CMP;
            end
            CMP:  state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            req_ready = '0;
            accept    = 1'b0;
        end
    end

    // rsp_valid is always high in RESP, so a ready there completes the op.
    assign done = (state == RESP) && rsp_ready;

    // Operand capture, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a_arr[grant];
                b_q     <= b_arr[grant];
                grant_q <= grant;
            end
            if (state == CMP) begin
                res_q     <= res_c;
                rsp_id    <= grant_q;
                rsp_valid <= 1'b1;
            end
            if (done) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= wrap_add(grant_q, IDW'(1));
            end
        end
    end

    assign rsp_g = res_q.g;
    assign rsp_l = res_q.l;
    assign rsp_e = res_q.e;
    assign busy  = (state != IDLE);

`ifdef CMP_SHARE_STATS_EN
    logic [EQ_CNT_W-1:0] eq_cnt_q;

    // Saturating count of completed equal results; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || stats_clr)
            eq_cnt_q <= '0;
        else if (done && res_q.e && (eq_cnt_q != EQ_CNT_W'(EQ_CNT_MAX)))
            eq_cnt_q <= eq_cnt_q + 1'b1;
    end

    assign eq_count = eq_cnt_q;
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter (NREQ=4, WIDTH=4).
// Inputs change 1 time unit after posedge; outputs are checked on negedge.
module tb_cmp_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_g, rsp_l, rsp_e, busy;
`ifdef CMP_SHARE_STATS_EN
    logic        stats_clr;
    logic [7:0]  eq_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cmp_share_arbiter #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_g     (rsp_g),
        .rsp_l     (rsp_l),
        .rsp_e     (rsp_e),
`ifdef CMP_SHARE_STATS_EN
        .stats_clr (stats_clr),
        .eq_count  (eq_count),
`endif
        .busy      (busy)
    );

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic       g;
        logic       l;
        logic       e;
    } vec_t;

    vec_t vecs[8];
    vec_t rr_vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cyc();
        rst       = 1'b1;
        req_valid = '0;
        next_cyc();
        rst = 1'b0;
    endtask

    // One isolated transaction from requester idx with rsp_ready high.
    task automatic do_op(input vec_t v, input string tag);
        next_cyc();
        req_valid            = 4'(1 << v.idx);
        req_a[v.idx*4 +: 4]  = v.a;
        req_b[v.idx*4 +: 4]  = v.b;
        rsp_ready            = 1'b1;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(1 << v.idx));
        next_cyc();
        req_valid = '0;
        @(negedge clk);
        chk({tag, ".cmp_no_rsp"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".cmp_busy"}, 32'(busy), 32'd1);
        next_cyc();
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(v.idx));
        chk({tag, ".gle"}, 32'({rsp_g, rsp_l, rsp_e}), 32'({v.g, v.l, v.e}));
    endtask

    initial begin
        vecs[0] = '{0, 4'd9,  4'd3,  1'b1, 1'b0, 1'b0};
        vecs[1] = '{1, 4'd3,  4'd9,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{2, 4'd7,  4'd7,  1'b0, 1'b0, 1'b1};
        vecs[3] = '{3, 4'd15, 4'd14, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{0, 4'd0,  4'd15, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{3, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1};
        vecs[6] = '{1, 4'd15, 4'd15, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2, 4'd1,  4'd0,  1'b1, 1'b0, 1'b0};

        rr_vecs[0] = '{0, 4'd5,  4'd5, 1'b0, 1'b0, 1'b1};
        rr_vecs[1] = '{1, 4'd2,  4'd7, 1'b0, 1'b1, 1'b0};
        rr_vecs[2] = '{2, 4'd15, 4'd0, 1'b1, 1'b0, 1'b0};
        rr_vecs[3] = '{3, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
        rr_vecs[4] = '{0, 4'd5,  4'd5, 1'b0, 1'b0, 1'b1};

        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
`ifdef CMP_SHARE_STATS_EN
        stats_clr = 1'b0;
`endif

        // Reset held 3 cycles with every requester valid.
        for (int c = 0; c < 3; c++) begin
            next_cyc();
            @(negedge clk);
            chk("rst.req_ready", 32'(req_ready), 32'd0);
        end
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_id", 32'(rsp_id), 32'd0);
        chk("rst.gle", 32'({rsp_g, rsp_l, rsp_e}), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        next_cyc();
        rst       = 1'b0;
        req_valid = '0;

        // Isolated transactions, including the 9 vs 3 single-request case.
        for (int i = 0; i < 8; i++)
            do_op(vecs[i], $sformatf("vec%0d", i));

        // Round-robin with all four requesters valid continuously.
        do_reset();
        req_valid = 4'hF;
        req_a     = {4'd0, 4'd15, 4'd2, 4'd5};
        req_b     = {4'd0, 4'd0,  4'd7, 4'd5};
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d.grant", k), 32'(req_ready), 32'(1 << rr_vecs[k].idx));
            next_cyc();
            @(negedge clk);
            chk($sformatf("rr%0d.cmp_ready", k), 32'(req_ready), 32'd0);
            next_cyc();
            @(negedge clk);
            chk($sformatf("rr%0d.rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("rr%0d.rsp_id", k), 32'(rsp_id), 32'(rr_vecs[k].idx));
            chk($sformatf("rr%0d.gle", k), 32'({rsp_g, rsp_l, rsp_e}),
                32'({rr_vecs[k].g, rr_vecs[k].l, rr_vecs[k].e}));
            chk($sformatf("rr%0d.resp_ready", k), 32'(req_ready), 32'd0);
            next_cyc();
        end

        // Backpressure: result held for 5 cycles, then released.
        do_reset();
        req_valid = 4'b0011;
        req_a     = {8'h00, 4'd2, 4'd4};
        req_b     = {8'h00, 4'd2, 4'd1};
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp.grant0", 32'(req_ready), 32'b0001);
        next_cyc();
        @(negedge clk);
        chk("bp.cmp_ready", 32'(req_ready), 32'd0);
        next_cyc();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp.hold", 32'({rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e, busy}),
                32'({1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1}));
            chk("bp.no_grant", 32'(req_ready), 32'd0);
            next_cyc();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp.release_valid", 32'(rsp_valid), 32'd1);
        next_cyc();
        @(negedge clk);
        chk("bp.after_valid", 32'(rsp_valid), 32'd0);
        chk("bp.next_grant", 32'(req_ready), 32'b0010);
        next_cyc();
        req_valid = '0;
        next_cyc();
        @(negedge clk);
        chk("bp.rsp1", 32'({rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e}),
            32'({1'b1, 2'd1, 1'b0, 1'b0, 1'b1}));

        // Reset during CMP: pointer sits at 3 before the reset.
        do_reset();
        do_op('{2, 4'd3, 4'd8, 1'b0, 1'b1, 1'b0}, "pre");
        next_cyc();
        req_valid = 4'b1010;
        req_a     = {4'd6, 4'd0, 4'd4, 4'd0};
        req_b     = {4'd1, 4'd0, 4'd9, 4'd0};
        @(negedge clk);
        chk("mid.grant3", 32'(req_ready), 32'b1000);
        next_cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("mid.rst_ready", 32'(req_ready), 32'd0);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.grant1", 32'(req_ready), 32'b0010);
        next_cyc();
        req_valid = '0;
        @(negedge clk);
        chk("mid.no_rsp", 32'(rsp_valid), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("mid.rsp1", 32'({rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e}),
            32'({1'b1, 2'd1, 1'b0, 1'b1, 1'b0}));

`ifdef CMP_SHARE_STATS_EN
        // 300 back-to-back equal compares saturate the counter.
        do_reset();
        req_valid = 4'b0001;
        req_a     = 16'h0007;
        req_b     = 16'h0007;
        rsp_ready = 1'b1;
        repeat (900) next_cyc();
        req_valid = '0;
        @(negedge clk);
        chk("stats.saturated", 32'(eq_count), 32'd255);
        next_cyc();
        stats_clr = 1'b1;
        next_cyc();
        stats_clr = 1'b0;
        @(negedge clk);
        chk("stats.cleared", 32'(eq_count), 32'd0);
        do_op('{0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1}, "st_eq");
        do_op('{0, 4'd4, 4'd3, 1'b1, 1'b0, 1'b0}, "st_ne");
        next_cyc();
        @(negedge clk);
        chk("stats.one", 32'(eq_count), 32'd1);
        // Clear coincides with an equal completion.
        req_valid = 4'b0001;
        req_a     = 16'h0002;
        req_b     = 16'h0002;
        next_cyc();
        req_valid = '0;
        next_cyc();
        stats_clr = 1'b1;
        @(negedge clk);
        chk("stats.clr_rsp", 32'({rsp_valid, rsp_e}), 32'b11);
        next_cyc();
        stats_clr = 1'b0;
        @(negedge clk);
        chk("stats.clr_wins", 32'(eq_count), 32'd0);
`endif

        next_cyc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
